// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcode constants, control bundle and immediate selector.
// The DECODE_M_EXT_EN macro (used in decode_stage) enables muldiv; the field exists in every build.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_R   = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    typedef struct packed {
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
        logic op_r;
        logic op_imm;
        logic load;
        logic store;
        logic muldiv;
        logic illegal;
    } ctrl_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_t;

endpackage

// File: rtl/decode_if.sv
// Upstream/downstream handshake bundle of the decode stage, including the pipeline flush.
// master = fetch/consumer side, slave = decode_stage.
interface decode_if
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    ctrl_t           out_ctrl;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_ctrl, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_ctrl, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm
    );
endinterface

// File: rtl/decode_imm_gen.sv
// Combinational RV32I immediate generator; every format is sign-extended from instr[31].
// Only instr[31:7] carries immediate bits, so the opcode field is not an input.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_instr,
    input  imm_sel_t        i_sel,
    output logic [XLEN-1:0] o_imm
);
    logic signed [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (i_sel)
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Signed size cast widens to XLEN by replicating bit 31.
    assign o_imm = XLEN'(w_imm32);
endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: class decode, illegal detection, output register plus one-entry skid.
// Define DECODE_M_EXT_EN to accept funct7=0x01 R-type encodings as muldiv instead of flagging them illegal.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic    clk,
    input  logic    rst,
    decode_if.slave bus
);
    typedef struct packed {
        logic [PC_W-1:0] pc;
        ctrl_t           ctrl;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
    } payload_t;

    logic [31:0]     w_instr;
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    ctrl_t           w_ctrl;
    imm_sel_t        w_sel;
    logic [XLEN-1:0] w_imm;
    payload_t        w_dec_p0;
    logic            w_acc;
    logic            w_or_free;

    payload_t        r_or_p1;
    payload_t        r_sk_p1;
    logic            r_or_vld_p1;
    logic            r_sk_vld_p1;

    assign w_instr = bus.in_instr;
    assign w_opc   = w_instr[6:0];
    assign w_f3    = w_instr[14:12];
    assign w_f7    = w_instr[31:25];

    always_comb begin
        w_ctrl = '0;
        w_sel  = IMM_NONE;
        case (w_opc)
            OPC_LOAD: begin
                w_ctrl.load = 1'b1;
                w_sel       = IMM_I;
                if (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7) w_ctrl.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                w_ctrl.op_imm = 1'b1;
                w_sel         = IMM_I;
            end
            OPC_AUIPC: begin
                w_ctrl.auipc = 1'b1;
                w_sel        = IMM_U;
            end
            OPC_STORE: begin
                w_ctrl.store = 1'b1;
                w_sel        = IMM_S;
                if (w_f3 >= 3'd3) w_ctrl.illegal = 1'b1;
            end
            OPC_OP_R: begin
                if (w_f7 == 7'h00) begin
                    w_ctrl.op_r = 1'b1;
                end else if (w_f7 == 7'h20) begin
                    w_ctrl.op_r = 1'b1;
                    if (w_f3 != 3'd0 && w_f3 != 3'd5) w_ctrl.illegal = 1'b1;
`ifdef DECODE_M_EXT_EN
                end else if (w_f7 == 7'h01) begin
                    w_ctrl.muldiv = 1'b1;
`endif
                end else begin
                    w_ctrl.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                w_ctrl.lui = 1'b1;
                w_sel      = IMM_U;
            end
            OPC_BRANCH: begin
                w_ctrl.branch = 1'b1;
                w_sel         = IMM_B;
                if (w_f3 == 3'd2 || w_f3 == 3'd3) w_ctrl.illegal = 1'b1;
            end
            OPC_JALR: begin
                w_ctrl.jalr = 1'b1;
                w_sel       = IMM_I;
                if (w_f3 != 3'd0) w_ctrl.illegal = 1'b1;
            end
            OPC_JAL: begin
                w_ctrl.jal = 1'b1;
                w_sel      = IMM_J;
            end
            default: w_ctrl.illegal = 1'b1;
        endcase
        if (w_instr[1:0] != 2'b11) w_ctrl.illegal = 1'b1;
        // An illegal entry carries no class flag and a zero immediate.
        if (w_ctrl.illegal) begin
            w_ctrl         = '0;
            w_ctrl.illegal = 1'b1;
            w_sel          = IMM_NONE;
        end
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr (w_instr[31:7]),
        .i_sel   (w_sel),
        .o_imm   (w_imm)
    );

    always_comb begin
        w_dec_p0        = '0;
        w_dec_p0.pc     = bus.in_pc;
        w_dec_p0.ctrl   = w_ctrl;
        w_dec_p0.rd     = w_instr[11:7];
        w_dec_p0.rs1    = w_instr[19:15];
        w_dec_p0.rs2    = w_instr[24:20];
        w_dec_p0.funct3 = w_f3;
        w_dec_p0.funct7 = w_f7;
        w_dec_p0.imm    = w_imm;
    end

    // p0 -> p1: in_ready depends only on the skid valid bit, never on out_ready.
    assign w_acc     = bus.in_valid && !r_sk_vld_p1;
    assign w_or_free = !r_or_vld_p1 || bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_or_vld_p1 <= 1'b0;
            r_sk_vld_p1 <= 1'b0;
            r_or_p1     <= '0;
            r_sk_p1     <= '0;
        end else if (bus.flush) begin
            r_or_vld_p1 <= 1'b0;
            r_sk_vld_p1 <= 1'b0;
        end else if (w_or_free) begin
            if (r_sk_vld_p1) begin
                r_or_p1     <= r_sk_p1;
                r_or_vld_p1 <= 1'b1;
                r_sk_vld_p1 <= 1'b0;
            end else if (w_acc) begin
                r_or_p1     <= w_dec_p0;
                r_or_vld_p1 <= 1'b1;
            end else begin
                r_or_vld_p1 <= 1'b0;
            end
        end else if (w_acc) begin
            r_sk_p1     <= w_dec_p0;
            r_sk_vld_p1 <= 1'b1;
        end
    end

    assign bus.in_ready   = !r_sk_vld_p1;
    assign bus.out_valid  = r_or_vld_p1;
    assign bus.out_pc     = r_or_p1.pc;
    assign bus.out_ctrl   = r_or_p1.ctrl;
    assign bus.out_rd     = r_or_p1.rd;
    assign bus.out_rs1    = r_or_p1.rs1;
    assign bus.out_rs2    = r_or_p1.rs2;
    assign bus.out_funct3 = r_or_p1.funct3;
    assign bus.out_funct7 = r_or_p1.funct7;
    assign bus.out_imm    = r_or_p1.imm;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a scoreboard queue of expected output beats.
// Build with or without DECODE_M_EXT_EN; the mul expectation follows the macro.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int B_ILL = 0, B_MD = 1, B_ST = 2, B_LD = 3, B_OPI = 4, B_OPR = 5;
    localparam int B_AUI = 6, B_LUI = 7, B_JALR = 8, B_JAL = 9, B_BR = 10;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        ctrl_t       ctrl;
        logic [31:0] imm;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    decode_if #(.XLEN(32), .PC_W(32)) bus ();
    decode_stage #(.XLEN(32), .PC_W(32)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic ctrl_t one(input int b);
        logic [10:0] v;
        v = 11'd1 << b;
        return ctrl_t'(v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction, wait (bounded) for in_ready, record the expected beat.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input ctrl_t c, input logic [31:0] imm);
        int   n;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = pc;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        e.pc = pc; e.instr = ins; e.ctrl = c; e.imm = imm;
        q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            chk("beat_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_pc", bus.out_pc, e.pc);
                chk("out_ctrl", bus.out_ctrl, e.ctrl);
                chk("out_rd", bus.out_rd, e.instr[11:7]);
                chk("out_rs1", bus.out_rs1, e.instr[19:15]);
                chk("out_rs2", bus.out_rs2, e.instr[24:20]);
                chk("out_funct3", bus.out_funct3, e.instr[14:12]);
                chk("out_funct7", bus.out_funct7, e.instr[31:25]);
                chk("out_imm", bus.out_imm, e.imm);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_ctrl", bus.out_ctrl, 0);
        chk("rst_out_imm", bus.out_imm, 0);
        chk("rst_out_pc", bus.out_pc, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // addi x1,x0,-1 : one-cycle latency
        bus.out_ready = 1'b1;
        send(32'hFFF00093, 32'h100, one(B_OPI), 32'hFFFFFFFF);
        chk("latency_valid", bus.out_valid, 1);
        chk("addi_rd", bus.out_rd, 1);

        // jal x1,8 then beq x0,x0,8 back-to-back
        send(32'h008000EF, 32'h104, one(B_JAL), 32'h8);
        send(32'h00000463, 32'h108, one(B_BR), 32'h8);
        chk("b2b_valid", bus.out_valid, 1);
        chk("b2b_pc", bus.out_pc, 32'h108);

        // further formats and legality corners at full rate
        send(32'hFE000FA3, 32'h10C, one(B_ST), 32'hFFFFFFFF);
        send(32'hFE000EE3, 32'h110, one(B_BR), 32'hFFFFFFFC);
        send(32'h00008067, 32'h114, one(B_JALR), 32'h0);
        send(32'hFFFFF197, 32'h118, one(B_AUI), 32'hFFFFF000);
        send(32'h403100B3, 32'h11C, one(B_OPR), 32'h0);
        send(32'h00000000, 32'h120, one(B_ILL), 32'h0);
        send(32'h00002063, 32'h124, one(B_ILL), 32'h0);
        send(32'h00003003, 32'h128, one(B_ILL), 32'h0);
        send(32'h00003023, 32'h12C, one(B_ILL), 32'h0);
        send(32'h00001067, 32'h130, one(B_ILL), 32'h0);
        send(32'h40001033, 32'h134, one(B_ILL), 32'h0);
        send(32'h00000012, 32'h138, one(B_ILL), 32'h0);
`ifdef DECODE_M_EXT_EN
        send(32'h022081B3, 32'h13C, one(B_MD), 32'h0);
`else
        send(32'h022081B3, 32'h13C, one(B_ILL), 32'h0);
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("idle_valid", bus.out_valid, 0);

        // A to OR, B to SK under backpressure, C held upstream
        bus.out_ready = 1'b0;
        send(32'h00A00113, 32'h200, one(B_OPI), 32'hA);
        send(32'h123452B7, 32'h204, one(B_LUI), 32'h12345000);
        chk("skid_full_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1; bus.in_instr = 32'h00112223; bus.in_pc = 32'h208;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stall_ready", bus.in_ready, 0);
        chk("stall_pc", bus.out_pc, 32'h200);
        chk("stall_imm", bus.out_imm, 32'hA);
        begin
            exp_t e;
            e.pc = 32'h208; e.instr = 32'h00112223; e.ctrl = one(B_ST); e.imm = 32'h4;
            q.push_back(e);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_b_valid", bus.out_valid, 1);
        chk("release_b_pc", bus.out_pc, 32'h204);
        chk("release_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("release_c_valid", bus.out_valid, 1);
        chk("release_c_pc", bus.out_pc, 32'h208);
        @(posedge clk); #1;

        // flush with OR and SK full and a new input offered
        bus.out_ready = 1'b0;
        send(32'h00100093, 32'h300, one(B_OPI), 32'h1);
        send(32'h00200093, 32'h304, one(B_OPI), 32'h2);
        bus.in_valid = 1'b1; bus.in_instr = 32'h00300093; bus.in_pc = 32'h308;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        q.delete();
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("flush_no_beat", bus.out_valid, 0);

        // asynchronous reset mid-cycle with OR and SK full
        bus.out_ready = 1'b0;
        send(32'h00100093, 32'h400, one(B_OPI), 32'h1);
        send(32'h00200093, 32'h404, one(B_OPI), 32'h2);
        bus.in_valid = 1'b1; bus.in_instr = 32'h00300093; bus.in_pc = 32'h408;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_ready", bus.in_ready, 1);
        chk("arst_ctrl", bus.out_ctrl, 0);
        chk("arst_imm", bus.out_imm, 0);
        chk("arst_pc", bus.out_pc, 0);
        q.delete();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(32'hFFF00093, 32'h500, one(B_OPI), 32'hFFFFFFFF);
        chk("post_rst_valid", bus.out_valid, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
